// File: rtl/sdram_line_reader.sv
// ---------------------------------------------------------------------------
// sdram_line_reader
//
// Client-side burst read engine for the async SDRAM controller. A line read
// is started with a word address and a length in 8-word bursts. The block
// pushes burst read commands into the controller's burst command FIFO. It
// pops 128-bit bursts from the controller's burst data FIFO and serialises
// each burst into a 16-bit pixel stream with valid/ready handshaking. Pixels
// come out in ascending address order: burst bits [127:112] go out first.
//
// Optional feature macro: SDRAM_LINE_READER_UNDERRUN_EN
//   When this macro is defined, the block adds underrun_cnt_o[15:0]. The
//   counter saturates at 16'hFFFF. It counts RUN cycles in which downstream
//   is ready, no pixel is available, and the line is not yet complete. It
//   clears on an accepted start.
//
// Ports
//   clk               single clock for all logic
//   rst_n_i           asynchronous active-low reset
//   start_i           one-cycle line read request (ignored while running)
//   base_addr_i[23:0] start word address, bits [2:0] forced to 0
//   len_i             number of 8-word bursts (0 = immediate done)
//   busy_o            high from accepted start until last pixel handshake
//   done_o            one-cycle pulse after the last pixel handshake
//   cmd_burst_d_o     burst command {8'b0, word address}
//   cmd_burst_enq_o   enqueue strobe to the burst command FIFO
//   cmd_burst_full_i  burst command FIFO full
//   burst_q_i         burst data FIFO head (first-word-fall-through)
//   burst_deq_o       pop the burst data FIFO head at this edge
//   burst_empty_i     burst data FIFO empty
//   pix_o             pixel word
//   pix_valid_o       pix_o valid
//   pix_ready_i       downstream accepts the pixel
//   pix_last_o        final pixel of the line
//   underrun_cnt_o    (optional) pixel underrun cycle count
// ---------------------------------------------------------------------------
module sdram_line_reader #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 12
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [23:0]          base_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          cmd_burst_d_o,
  output logic                 cmd_burst_enq_o,
  input  logic                 cmd_burst_full_i,
  input  logic [127:0]         burst_q_i,
  output logic                 burst_deq_o,
  input  logic                 burst_empty_i,
  output logic [15:0]          pix_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic                 pix_last_o
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
  ,
  output logic [15:0]          underrun_cnt_o
`endif
);

  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [23:0]          base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] received_q, received_d;
  logic [3:0]           outstanding_q, outstanding_d;
  logic [127:0]         shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 loaded_q, loaded_d;
  logic                 enq_q, enq_d;
  logic [23:0]          cmd_addr_q, cmd_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
  logic [15:0]          underrun_q, underrun_d;
`endif

  logic        run;
  logic        can_issue;
  logic        deq;
  logic        pix_hs;
  logic        burst_end_hs;
  logic        last_word;
  logic [23:0] issue_addr;

  // ---- control decode --------------------------------------------------
  assign run       = (state_q == ST_RUN);
  assign last_word = loaded_q && (idx_q == 3'd7) &&
                     (received_q == len_q - LEN_WIDTH'(1));

  // An enqueue is never issued in the cycle right after another one. This
  // gives the command FIFO's registered full flag a cycle to catch up.
  assign can_issue = run && (issued_q < len_q) && (outstanding_q < OUT_MAX) &&
                     !cmd_burst_full_i && !enq_q;

  // The next burst is popped either into an empty shift register, or in the
  // cycle when the eighth word is accepted. The second case lets bursts
  // stream back-to-back with no bubble between them.
  assign deq = run && (outstanding_q != 4'd0) && !burst_empty_i &&
               (!loaded_q || ((idx_q == 3'd7) && pix_ready_i));

  assign pix_hs       = loaded_q && pix_ready_i;
  assign burst_end_hs = pix_hs && (idx_q == 3'd7);

  // Address arithmetic wraps modulo 2^24.
  assign issue_addr = base_q + (24'(issued_q) << 3);

  // ---- next-state logic ------------------------------------------------
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    loaded_d      = loaded_q;
    enq_d         = 1'b0;
    cmd_addr_d    = cmd_addr_q;
    done_d        = 1'b0;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
    underrun_d    = underrun_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d        = base_addr_i & 24'hFFFFF8;
          len_d         = len_i;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = 4'd0;
          loaded_d      = 1'b0;
          idx_d         = 3'd0;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
          underrun_d    = 16'd0;
`endif
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (burst_end_hs && last_word) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ---- command issuer ------------------------------------------------
    if (can_issue) begin
      enq_d      = 1'b1;
      cmd_addr_d = issue_addr;
      issued_d   = issued_q + LEN_WIDTH'(1);
    end

    case ({can_issue, deq})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // ---- unpacker ------------------------------------------------------
    if (pix_hs) begin
      shift_d = {shift_q[111:0], 16'h0000};
      idx_d   = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        received_d = received_q + LEN_WIDTH'(1);
        loaded_d   = 1'b0;
      end
    end
    // A pop in the same cycle as the last-word handshake takes priority.
    if (deq) begin
      shift_d  = burst_q_i;
      loaded_d = 1'b1;
      idx_d    = 3'd0;
    end

`ifdef SDRAM_LINE_READER_UNDERRUN_EN
    if (run && pix_ready_i && !loaded_q && (received_q < len_q) &&
        (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
`endif
  end

  always_comb begin
    busy_d = (state_d == ST_RUN);
  end

  // ---- register stage --------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= 4'd0;
      shift_q       <= '0;
      idx_q         <= 3'd0;
      loaded_q      <= 1'b0;
      enq_q         <= 1'b0;
      cmd_addr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
      underrun_q    <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      loaded_q      <= loaded_d;
      enq_q         <= enq_d;
      cmd_addr_q    <= cmd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
      underrun_q    <= underrun_d;
`endif
    end
  end

  // ---- outputs ---------------------------------------------------------
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign cmd_burst_enq_o = enq_q;
  assign cmd_burst_d_o   = {8'h00, cmd_addr_q};
  assign burst_deq_o     = deq;
  assign pix_o           = shift_q[127:112];
  assign pix_valid_o     = loaded_q;
  assign pix_last_o      = last_word;
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
  assign underrun_cnt_o  = underrun_q;
`endif

endmodule

// File: doc/sdram_line_reader.md
Name: sdram_line_reader

Overview:
- Client-side burst read engine for the async SDRAM controller. Given a start word address and a length in 8-word bursts, it pushes burst read commands into the controller's burst command FIFO.
- It pops 128-bit burst data from the controller's burst data FIFO and serialises each burst into a 16-bit pixel stream with valid/ready.
- Sits in the video/reader clock domain: it drives the writer_burst_* port and consumes the reader_burst_* port.

Parameters:
- MAX_OUTSTANDING, 4: max bursts issued but not yet popped from the data FIFO (1..15).
- LEN_WIDTH, 12: width of the burst count.

Ports:
- clk  in  1  single clock for all logic
- rst_n_i  in  1  reset, asynchronous assert, active-low
- start_i  in  1  one-cycle request to start a line read
- base_addr_i  in  24  start word address; bits [2:0] ignored (forced 0)
- len_i  in  LEN_WIDTH  number of 8-word bursts
- busy_o  out  1  high from accepted start until last pixel handshake
- done_o  out  1  one-cycle pulse after last pixel handshake
- cmd_burst_d_o  out  32  burst command: {8'b0, word address}
- cmd_burst_enq_o  out  1  enqueue strobe to the burst command FIFO
- cmd_burst_full_i  in  1  burst command FIFO full
- burst_q_i  in  128  burst data FIFO head (first-word-fall-through)
- burst_deq_o  out  1  pop burst data FIFO head at this edge
- burst_empty_i  in  1  burst data FIFO empty
- pix_o  out  16  pixel word
- pix_valid_o  out  1  pix_o valid
- pix_ready_i  in  1  downstream accepts
- pix_last_o  out  1  marks final word of the line

Behaviour:
- Reset (rst_n_i low, async): state IDLE; all counters and the shift register cleared. All outputs 0: busy_o, done_o, cmd_burst_enq_o, cmd_burst_d_o, burst_deq_o, pix_valid_o, pix_last_o, pix_o.
- States: IDLE, RUN.
- IDLE + start_i:
  - Latch base_addr_i & ~7 and len_i.
  - If len_i==0: stay IDLE, pulse done_o next cycle, issue nothing.
  - Else: go to RUN, busy_o=1 next cycle.
- start_i in RUN: ignored.
- Issuer (RUN), registered outputs:
  - Condition: issued<len && outstanding<MAX_OUTSTANDING && !cmd_burst_full_i, and cmd_burst_enq_o not asserted in the previous cycle.
  - Action: cmd_burst_enq_o=1 for one cycle; cmd_burst_d_o={8'b0, base+8*issued} (24-bit, wraps mod 2^24); issued++, outstanding++.
  - Net effect: at most one command per two cycles, so the registered full flag is never overrun.
- Outstanding counter:
  - +1 on enqueue, -1 on burst_deq_o.
  - Both in the same cycle: unchanged.
- Unpacker:
  - burst_deq_o is combinational = RUN && outstanding>0 && !burst_empty_i && (!loaded || (idx==7 && pix_ready_i)).
  - On deq: shift register <= burst_q_i, loaded=1, idx=0.
- Pixel output:
  - pix_o = shift[127:112]; pix_valid_o = loaded.
  - On valid&&ready: shift <<= 16, idx++.
  - At idx==7 handshake: received++, and loaded clears unless reloaded in the same cycle.
  - Word order is ascending address: burst [127:112] first.
  - pix_o and pix_valid_o are held stable while !pix_ready_i.
- pix_last_o = loaded && idx==7 && received==len-1.
- On the last handshake: next cycle RUN->IDLE, busy_o=0, done_o=1 for one cycle.
- Throughput: with back-to-back data and pix_ready_i high, one pixel per cycle with no bubble between bursts.
- Reset mid-line: the block clears immediately. Controller FIFOs must be reset by the same reset to discard in-flight data; this is a system integration rule.

Optional Feature:
- Macro: SDRAM_LINE_READER_UNDERRUN_EN.
- Defined: adds output underrun_cnt_o[15:0]. It increments (saturating at 16'hFFFF) each RUN cycle with pix_ready_i && !pix_valid_o && received<len, and clears on an accepted start.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- base=24'h000100, len=2, FIFOs ideal, ready=1 -> cmd_burst_d_o 32'h00000100 then 32'h00000108; 16 pixels in order of burst words [127:112]..[15:0]; pix_last_o on the 16th; done_o 1 cycle later.
- base=24'h000105, len=1 -> command address 32'h00000100 (low bits cleared).
- len=20, MAX_OUTSTANDING=4, data FIFO never filled by model -> exactly 4 enqueues, then no more until a burst is popped.
- cmd_burst_full_i held 1 for 10 cycles mid-line -> no enqueue while full; all 20 addresses issued exactly once, in order.
- pix_ready_i toggling 1/0 each cycle, len=3 -> 24 pixels, none dropped or duplicated, pix_o stable while stalled.
- start with len=0 -> done_o pulse next cycle, zero enqueues; base=24'hFFFFF8, len=2 -> second address 32'h00000000; rst_n_i low mid-line -> all outputs 0 asynchronously.
